cond_unit_pipe: RTL and testbench

Parametrised successor to the single-cycle conditional-execution unit in the pipelined RSA CPU. It sits in the EX stage. It evaluates the 4-bit ARM condition field against the architectural NZCV flags, gates the PC/register/memory write strobes, and updates the flags in configurable write groups. It adds pipeline stall/flush qualification, optional registered outputs, and an exception flag-save stack: entry pushes NZCV, return pops it.

---
 rtl/cond_pkg.sv | 46 ++++
 rtl/cond_unit_pipe_flag_save_stack.sv | 62 ++++++
 rtl/cond_unit_pipe.sv | 154 +++++++++++++++
 tb/tb_cond_unit_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: condition-code encoding, NZCV bit positions and the shared condcheck evaluator
// used by the conditional-execution unit and its flag-save stack.
package cond_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
    } cond_t;

    // Code 15 is treated as unconditional, same as AL.
    function automatic logic condcheck(input cond_t cond, input logic [FLAG_W-1:0] flags);
        logic n, z, c, v, res;
        n   = flags[FLAG_N];
        z   = flags[FLAG_Z];
        c   = flags[FLAG_C];
        v   = flags[FLAG_V];
        res = 1'b1;
        case (cond)
            EQ:      res = z;
            NE:      res = ~z;
            CS:      res = c;
            CC:      res = ~c;
            MI:      res = n;
            PL:      res = ~n;
            VS:      res = v;
            VC:      res = ~v;
            HI:      res = c & ~z;
            LS:      res = ~c | z;
            GE:      res = (n == v);
            LT:      res = (n != v);
            GT:      res = ~z & (n == v);
            LE:      res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_unit_pipe_flag_save_stack.sv
// flag_save_stack: LIFO of NZCV snapshots with an occupancy count, full/empty status and
// single-cycle overflow/underflow pulses; refused pushes and pops leave the contents untouched.
module flag_save_stack
    import cond_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FLAG_W-1:0] data_i,
    output logic [FLAG_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              doPush, doPop;
    logic [AW-1:0]     wrIdx, topIdx;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign doPush      = push_i & ~full_o;
    assign doPop       = pop_i & ~empty_o;
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & empty_o;
    assign wrIdx       = AW'(count_q);
    assign topIdx      = AW'(count_q - CW'(1));
    assign data_o      = mem_q[topIdx];

    always_comb begin
        count_d = count_q;
        if (doPush) begin
            count_d = count_q + CW'(1);
        end else if (doPop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Only the count is reset; entries above it are never read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrIdx] <= data_i;
        end
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe: EX-stage conditional execution with stall/flush gating, grouped NZCV writes,
// optional registered strobes and an exception flag-save stack (define COND_SAVE_STACK_EN).
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int FLAG_GROUPS = 2,
    parameter int SAVE_DEPTH  = 2,
    parameter int OUT_REG     = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [3:0]             cond_i,
    input  logic [FLAG_W-1:0]      alu_flags_i,
    input  logic [FLAG_GROUPS-1:0] flag_w_i,
    input  logic                   pcs_i,
    input  logic                   reg_w_i,
    input  logic                   mem_w_i,
    input  logic                   exc_entry_i,
    input  logic                   exc_return_i,
    input  logic                   err_clr_i,
    output logic                   pc_src_o,
    output logic                   reg_write_o,
    output logic                   mem_write_o,
    output logic                   cond_ex_o,
    output logic [FLAG_W-1:0]      flags_o,
    output logic                   save_full_o,
    output logic                   save_empty_o,
    output logic                   save_err_o
);

    localparam int GW = FLAG_W / FLAG_GROUPS;

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [FLAG_W-1:0] popData;
    logic              popLoad;
    logic              go;
    logic              pcSrcG, regWriteG, memWriteG;

    assign cond_ex_o = condcheck(cond_t'(cond_i), flags_q);
    assign go        = valid_i & ~stall_i & ~flush_i & ~exc_entry_i & ~exc_return_i & cond_ex_o;
    assign pcSrcG    = pcs_i & go;
    assign regWriteG = reg_w_i & go;
    assign memWriteG = mem_w_i & go;
    assign flags_o   = flags_q;

    // A pop restores the whole NZCV word and outranks any group write.
    always_comb begin
        flags_d = flags_q;
        if (popLoad) begin
            flags_d = popData;
        end else begin
            for (int g = 0; g < FLAG_GROUPS; g++) begin
                if (flag_w_i[g] & go) begin
                    flags_d[g*GW +: GW] = alu_flags_i[g*GW +: GW];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : gen_out_reg
            logic pcSrc_q, regWrite_q, memWrite_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pcSrc_q    <= 1'b0;
                    regWrite_q <= 1'b0;
                    memWrite_q <= 1'b0;
                end else begin
                    pcSrc_q    <= pcSrcG;
                    regWrite_q <= regWriteG;
                    memWrite_q <= memWriteG;
                end
            end

            assign pc_src_o    = pcSrc_q;
            assign reg_write_o = regWrite_q;
            assign mem_write_o = memWrite_q;
        end else begin : gen_out_comb
            assign pc_src_o    = pcSrcG;
            assign reg_write_o = regWriteG;
            assign mem_write_o = memWriteG;
        end
    endgenerate

`ifdef COND_SAVE_STACK_EN
    logic saveErr_q, saveErr_d;
    logic pushReq, popReq, bothReq;
    logic overflow, underflow, stackEmpty;

    assign bothReq = exc_entry_i & exc_return_i;
    assign pushReq = exc_entry_i & ~exc_return_i;
    assign popReq  = exc_return_i & ~exc_entry_i;

    flag_save_stack #(
        .DEPTH(SAVE_DEPTH)
    ) u_stack (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (pushReq),
        .pop_i      (popReq),
        .data_i     (flags_q),
        .data_o     (popData),
        .full_o     (save_full_o),
        .empty_o    (stackEmpty),
        .overflow_o (overflow),
        .underflow_o(underflow)
    );

    assign save_empty_o = stackEmpty;
    assign popLoad      = popReq & ~stackEmpty;
    assign save_err_o   = saveErr_q;

    // Sticky error: a new error in the same cycle beats ErrClr.
    always_comb begin
        saveErr_d = saveErr_q;
        if (err_clr_i) begin
            saveErr_d = 1'b0;
        end
        if (overflow | underflow | bothReq) begin
            saveErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            saveErr_q <= 1'b0;
        end else begin
            saveErr_q <= saveErr_d;
        end
    end
`else
    logic unusedErrClr;

    assign unusedErrClr = err_clr_i;
    assign popLoad      = 1'b0;
    assign popData      = '0;
    assign save_full_o  = 1'b0;
    assign save_empty_o = 1'b1;
    assign save_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cond_unit_pipe.sv
// tb_cond_unit_pipe: directed checks of condition gating, grouped flag writes, registered strobes,
// the flag-save stack (when COND_SAVE_STACK_EN is defined) and asynchronous reset.
module tb_cond_unit_pipe;
   import cond_pkg::*;

   logic       clk = 1'b0;
   logic       rstN;
   logic       valid, stall, flush;
   logic [3:0] cond, aluFlags;
   logic [1:0] flagW;
   logic       pcs, regW, memW, excEntry, excReturn, errClr;

   logic       pcSrc0, regWrite0, memWrite0, condEx0, full0, empty0, err0;
   logic [3:0] flags0;
   logic       unusedPcSrc1, unusedRegWrite1, unusedCondEx1, unusedFull1, unusedEmpty1, unusedErr1;
   logic       memWrite1;
   logic [3:0] flags1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cond_unit_pipe #(.FLAG_GROUPS(2), .SAVE_DEPTH(2), .OUT_REG(0)) dut (
      .clk_i(clk), .rst_ni(rstN), .valid_i(valid), .stall_i(stall), .flush_i(flush),
      .cond_i(cond), .alu_flags_i(aluFlags), .flag_w_i(flagW), .pcs_i(pcs), .reg_w_i(regW),
      .mem_w_i(memW), .exc_entry_i(excEntry), .exc_return_i(excReturn), .err_clr_i(errClr),
      .pc_src_o(pcSrc0), .reg_write_o(regWrite0), .mem_write_o(memWrite0), .cond_ex_o(condEx0),
      .flags_o(flags0), .save_full_o(full0), .save_empty_o(empty0), .save_err_o(err0)
   );

   cond_unit_pipe #(.FLAG_GROUPS(2), .SAVE_DEPTH(2), .OUT_REG(1)) dutReg (
      .clk_i(clk), .rst_ni(rstN), .valid_i(valid), .stall_i(stall), .flush_i(flush),
      .cond_i(cond), .alu_flags_i(aluFlags), .flag_w_i(flagW), .pcs_i(pcs), .reg_w_i(regW),
      .mem_w_i(memW), .exc_entry_i(excEntry), .exc_return_i(excReturn), .err_clr_i(errClr),
      .pc_src_o(unusedPcSrc1), .reg_write_o(unusedRegWrite1), .mem_write_o(memWrite1),
      .cond_ex_o(unusedCondEx1), .flags_o(flags1), .save_full_o(unusedFull1),
      .save_empty_o(unusedEmpty1), .save_err_o(unusedErr1)
   );

   // Drive one cycle's worth of inputs and let the combinational paths settle.
   task automatic applyStimulus(input logic v, input logic st, input logic fl, input logic [3:0] c,
                                input logic [3:0] alu, input logic [1:0] fw, input logic p,
                                input logic r, input logic m, input logic en, input logic ret,
                                input logic clr);
      valid = v; stall = st; flush = fl; cond = c; aluFlags = alu; flagW = fw;
      pcs = p; regW = r; memW = m; excEntry = en; excReturn = ret; errClr = clr;
      #3;
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkOutput(tag, {3'b000, observed}, {3'b000, expected});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b0;
      applyStimulus(0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0, 0, 0, 0);
      checkOutput("resetFlags", flags0, 4'b0000);
      checkBit("resetEmpty", empty0, 1'b1);
      checkBit("resetFull", full0, 1'b0);
      checkBit("resetErr", err0, 1'b0);
      checkBit("resetMemReg", memWrite1, 1'b0);
      #9 rstN = 1'b1;
      nextCycle;

      // Stall / flush suppression with Z set
      applyStimulus(1, 0, 0, AL, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0);
      nextCycle;
      checkOutput("flagsInit", flags0, 4'b0100);
      applyStimulus(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0);
      checkBit("regWriteEq", regWrite0, 1'b1);
      checkBit("condExEq", condEx0, 1'b1);
      applyStimulus(1, 1, 0, EQ, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0);
      checkBit("regWriteStall", regWrite0, 1'b0);
      nextCycle;
      checkOutput("flagsStall", flags0, 4'b0100);
      applyStimulus(1, 0, 1, EQ, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0);
      checkBit("regWriteFlush", regWrite0, 1'b0);
      nextCycle;
      checkOutput("flagsFlush", flags0, 4'b0100);
      applyStimulus(1, 0, 0, NE, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0);
      checkBit("condExNe", condEx0, 1'b0);
      checkBit("pcSrcNe", pcSrc0, 1'b0);

      // Group writes: high group then low group
      applyStimulus(1, 0, 0, AL, 4'b1010, 2'b10, 0, 0, 0, 0, 0, 0);
      nextCycle;
      checkOutput("flagsGrpHi", flags0, 4'b1000);
      applyStimulus(1, 0, 0, MI, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0);
      checkBit("condExMi", condEx0, 1'b1);
      checkBit("pcSrcMi", pcSrc0, 1'b1);
      applyStimulus(1, 0, 0, PL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      checkBit("condExPl", condEx0, 1'b0);
      applyStimulus(1, 0, 0, AL, 4'b0111, 2'b01, 0, 0, 0, 0, 0, 0);
      nextCycle;
      checkOutput("flagsGrpLo", flags0, 4'b1011);
      applyStimulus(1, 0, 0, GE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      checkBit("condExGe", condEx0, 1'b1);
      applyStimulus(1, 0, 0, HI, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      checkBit("condExHi", condEx0, 1'b1);
      applyStimulus(1, 0, 0, LE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      checkBit("condExLe", condEx0, 1'b0);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0);
      checkBit("regWriteInvalid", regWrite0, 1'b0);

      // Registered strobes
      applyStimulus(1, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0);
      checkBit("memComb", memWrite0, 1'b1);
      checkBit("memRegPre", memWrite1, 1'b0);
      nextCycle;
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      checkBit("memRegN1", memWrite1, 1'b1);
      checkBit("memCombOff", memWrite0, 1'b0);
      nextCycle;
      checkBit("memRegN2", memWrite1, 1'b0);
      applyStimulus(1, 1, 0, AL, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0);
      nextCycle;
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      checkBit("memRegStall", memWrite1, 1'b0);
      checkOutput("flagsRegInst", flags1, 4'b1011);

`ifdef COND_SAVE_STACK_EN
      // Save stack round trip with depth 2
      applyStimulus(1, 0, 0, AL, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 0);
      nextCycle;
      checkOutput("flagsPre0", flags0, 4'b0110);
      applyStimulus(1, 0, 0, AL, 4'b0000, 2'b00, 1, 1, 1, 1, 0, 0);
      checkBit("regWriteEntry", regWrite0, 1'b0);
      checkBit("pcSrcEntry", pcSrc0, 1'b0);
      nextCycle;
      checkBit("emptyPush1", empty0, 1'b0);
      checkOutput("flagsPush1", flags0, 4'b0110);
      applyStimulus(1, 0, 0, AL, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0);
      nextCycle;
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0);
      nextCycle;
      checkBit("fullPush2", full0, 1'b1);
      checkBit("errPush2", err0, 1'b0);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0);
      nextCycle;
      checkBit("errOverflow", err0, 1'b1);
      checkBit("fullOverflow", full0, 1'b1);
      checkOutput("flagsOverflow", flags0, 4'b1001);
      applyStimulus(1, 0, 0, AL, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0);
      checkBit("regWriteReturn", regWrite0, 1'b0);
      nextCycle;
      checkOutput("flagsPop1", flags0, 4'b1001);
      checkBit("fullPop1", full0, 1'b0);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0);
      nextCycle;
      checkOutput("flagsPop2", flags0, 4'b0110);
      checkBit("emptyPop2", empty0, 1'b1);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 1);
      nextCycle;
      checkBit("errUnderflowWins", err0, 1'b1);
      checkOutput("flagsUnderflow", flags0, 4'b0110);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1);
      nextCycle;
      checkBit("errClr", err0, 1'b0);

      // Simultaneous entry and return with one entry stacked
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0);
      nextCycle;
      applyStimulus(1, 0, 0, AL, 4'b0011, 2'b11, 0, 0, 0, 0, 0, 0);
      nextCycle;
      checkOutput("flagsPreBoth", flags0, 4'b0011);
      applyStimulus(1, 0, 0, AL, 4'b1111, 2'b11, 1, 1, 1, 1, 1, 0);
      checkBit("pcSrcBoth", pcSrc0, 1'b0);
      checkBit("regWriteBoth", regWrite0, 1'b0);
      checkBit("memWriteBoth", memWrite0, 1'b0);
      nextCycle;
      checkOutput("flagsBoth", flags0, 4'b0011);
      checkBit("errBoth", err0, 1'b1);
      checkBit("emptyBoth", empty0, 1'b0);
      checkBit("fullBoth", full0, 1'b0);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0);
      nextCycle;
      checkOutput("flagsPopAfterBoth", flags0, 4'b0110);
      checkBit("emptyAfterBoth", empty0, 1'b1);

      applyStimulus(1, 0, 0, AL, 4'b1100, 2'b11, 0, 0, 0, 0, 0, 0);
      nextCycle;
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 0);
      nextCycle;
      checkBit("emptyBeforeReset", empty0, 1'b0);
`else
      // Without the stack, exceptions only suppress strobes and flag writes
      applyStimulus(1, 0, 0, AL, 4'b1111, 2'b11, 1, 1, 1, 1, 0, 0);
      checkBit("regWriteEntry", regWrite0, 1'b0);
      checkBit("pcSrcEntry", pcSrc0, 1'b0);
      nextCycle;
      checkOutput("flagsEntry", flags0, 4'b1011);
      applyStimulus(1, 0, 0, AL, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 0);
      checkBit("memWriteReturn", memWrite0, 1'b0);
      nextCycle;
      checkOutput("flagsReturn", flags0, 4'b1011);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 1, 1, 1);
      nextCycle;
      checkBit("errTiedLow", err0, 1'b0);
      checkBit("fullTiedLow", full0, 1'b0);
      checkBit("emptyTiedHigh", empty0, 1'b1);
      applyStimulus(1, 0, 0, AL, 4'b1100, 2'b11, 0, 0, 0, 0, 0, 0);
      nextCycle;
`endif

      // Asynchronous reset between clock edges
      checkOutput("flagsBeforeReset", flags0, 4'b1100);
      applyStimulus(0, 0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      rstN = 1'b0;
      #1;
      checkOutput("asyncResetFlags", flags0, 4'b0000);
      checkBit("asyncResetEmpty", empty0, 1'b1);
      checkOutput("asyncResetFlagsReg", flags1, 4'b0000);
      #2 rstN = 1'b1;
      nextCycle;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
